control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for a simple bus datapath.
// Sequences fetch (T0-T2) and execute (T3-T6) strobes.
module control_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] reg_out_en,
  output logic [15:0] reg_in_en,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  state_t state;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_alu;
  logic       is_md;
  logic       is_nop;
  logic       is_halt;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_alu  = opcode <= 5'd14;
  assign is_md   = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_nop  = opcode == 5'd27;
  assign is_halt = opcode == 5'd28;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state <= T0;
        T0:   state <= T1;
        T1:   if (mem_ready) state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_alu || is_md) state <= T4;
          else if (is_halt)    state <= HALT;
          else                 state <= T0;
        end
        T4:   state <= T5;
        T5:   state <= is_md ? T6 : T0;
        T6:   state <= T0;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; only the T1 completion strobes see mem_ready.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRread    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zhighin    = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    reg_out_en = 16'h0000;
    reg_in_en  = 16'h0000;
    alu_op     = 5'b00000;
    illegal_op = 1'b0;
    unique case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        MDRread = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
        Zlowout = mem_ready;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          reg_out_en = 16'(1) << rb;
          Yin        = 1'b1;
        end else if (is_md) begin
          reg_out_en = 16'(1) << ra;
          Yin        = 1'b1;
        end else if (!is_nop && !is_halt) begin
          illegal_op = 1'b1;
        end
      end
      T4: begin
        if (is_alu) begin
          reg_out_en = 16'(1) << rc;
          Zlowin     = 1'b1;
          alu_op     = opcode;
        end else if (is_md) begin
          reg_out_en = 16'(1) << rb;
          Zlowin     = 1'b1;
          Zhighin    = 1'b1;
          alu_op     = opcode;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else       reg_in_en = 16'(1) << ra;
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign run = (state != IDLE) && (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Each cycle compares the full packed output vector.
module tb_control_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin;
  logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] reg_out_en;
  logic [15:0] reg_in_en;
  logic [4:0]  alu_op;
  logic        run;
  logic        illegal_op;

  int n_chk;
  int n_pass;

  localparam logic [14:0] S_PCOUT = 15'h4000;
  localparam logic [14:0] S_PCIN  = 15'h2000;
  localparam logic [14:0] S_INCPC = 15'h1000;
  localparam logic [14:0] S_MARIN = 15'h0800;
  localparam logic [14:0] S_MDRRD = 15'h0400;
  localparam logic [14:0] S_MDRIN = 15'h0200;
  localparam logic [14:0] S_MDROU = 15'h0100;
  localparam logic [14:0] S_IRIN  = 15'h0080;
  localparam logic [14:0] S_YIN   = 15'h0040;
  localparam logic [14:0] S_ZLIN  = 15'h0020;
  localparam logic [14:0] S_ZHIN  = 15'h0010;
  localparam logic [14:0] S_ZLOUT = 15'h0008;
  localparam logic [14:0] S_ZHOUT = 15'h0004;
  localparam logic [14:0] S_LOIN  = 15'h0002;
  localparam logic [14:0] S_HIIN  = 15'h0001;

  localparam logic [14:0] E_T0 =
    S_PCOUT | S_MARIN | S_INCPC | S_ZLIN;
  localparam logic [14:0] E_T1 =
    S_MDRRD | S_MDRIN | S_PCIN | S_ZLOUT;
  localparam logic [14:0] E_T1W = S_MDRRD | S_MDRIN;
  localparam logic [14:0] E_T2  = S_MDROU | S_IRIN;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRread(MDRread), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin),
    .reg_out_en(reg_out_en), .reg_in_en(reg_in_en),
    .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [53:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRread, MDRin,
                MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout,
                Zhighout, LOin, HIin, reg_out_en, reg_in_en,
                alu_op, run, illegal_op};

  function automatic logic [53:0] ev(
    input logic [14:0] s, input logic [15:0] ro,
    input logic [15:0] ri, input logic [4:0] alu,
    input logic rn, input logic ill);
    return {s, ro, ri, alu, rn, ill};
  endfunction

  task automatic check(input string tag,
                       input logic [53:0] got,
                       input logic [53:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input string tag);
    cyc(); check({tag, "_t1"}, obs, ev(E_T1, 0, 0, 0, 1, 0));
    cyc(); check({tag, "_t2"}, obs, ev(E_T2, 0, 0, 0, 1, 0));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    ir = 32'h0;
    #1 check("reset", obs, '0);
    #10 reset_n = 1'b1;
    cyc(); check("idle", obs, '0);
    cyc(); check("idle_hold", obs, '0);

    // mul r6,r7
    start = 1'b1;
    ir = 32'h7B380000;
    cyc(); check("mul_t0", obs, ev(E_T0, 0, 0, 0, 1, 0));
    fetch("mul");
    cyc(); check("mul_t3", obs, ev(S_YIN, 16'h0040, 0, 0, 1, 0));
    cyc(); check("mul_t4", obs,
      ev(S_ZLIN | S_ZHIN, 16'h0080, 0, 5'b01111, 1, 0));
    cyc(); check("mul_t5", obs, ev(S_ZLOUT | S_LOIN, 0, 0, 0, 1, 0));
    cyc(); check("mul_t6", obs, ev(S_ZHOUT | S_HIIN, 0, 0, 0, 1, 0));
    cyc(); check("mul_t0n", obs, ev(E_T0, 0, 0, 0, 1, 0));

    // alu op 3: r2 <= r3 op r4; start left high to show it is ignored
    ir = 32'h191A0000;
    fetch("alu");
    cyc(); check("alu_t3", obs, ev(S_YIN, 16'h0008, 0, 0, 1, 0));
    cyc(); check("alu_t4", obs,
      ev(S_ZLIN, 16'h0010, 0, 5'b00011, 1, 0));
    cyc(); check("alu_t5", obs, ev(S_ZLOUT, 0, 16'h0004, 0, 1, 0));
    cyc(); check("alu_t0n", obs, ev(E_T0, 0, 0, 0, 1, 0));
    start = 1'b0;

    // nop with a three-cycle memory stall
    ir = 32'hD8000000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 mem_ready = (k == 3);
      #1 check($sformatf("stall_%0d", k), obs,
        ev((k == 3) ? E_T1 : E_T1W, 0, 0, 0, 1, 0));
    end
    cyc(); check("nop_t2", obs, ev(E_T2, 0, 0, 0, 1, 0));
    cyc(); check("nop_t3", obs, ev(0, 0, 0, 0, 1, 0));
    cyc(); check("nop_t0n", obs, ev(E_T0, 0, 0, 0, 1, 0));

    // halt, then restart via reset
    ir = 32'hE0000000;
    fetch("halt");
    cyc(); check("halt_t3", obs, ev(0, 0, 0, 0, 1, 0));
    start = 1'b1;
    cyc(); check("halt_st", obs, '0);
    cyc(); check("halt_hold", obs, '0);
    cyc(); check("halt_hold2", obs, '0);
    reset_n = 1'b0;
    #1 check("halt_rst", obs, '0);
    #2 reset_n = 1'b1;
    cyc(); check("restart_t0", obs, ev(E_T0, 0, 0, 0, 1, 0));
    start = 1'b0;

    // undefined opcode 11111
    ir = 32'hF8000000;
    fetch("ill");
    cyc(); check("ill_t3", obs, ev(0, 0, 0, 0, 1, 1));
    cyc(); check("ill_t0n", obs, ev(E_T0, 0, 0, 0, 1, 0));

    // undefined opcode 10001 takes the same path
    ir = 32'h88000000;
    fetch("ill2");
    cyc(); check("ill2_t3", obs, ev(0, 0, 0, 0, 1, 1));
    cyc(); check("ill2_t0n", obs, ev(E_T0, 0, 0, 0, 1, 0));

    // mul abandoned by reset in T4
    ir = 32'h7B380000;
    fetch("mulr");
    cyc(); check("mulr_t3", obs, ev(S_YIN, 16'h0040, 0, 0, 1, 0));
    cyc(); check("mulr_t4", obs,
      ev(S_ZLIN | S_ZHIN, 16'h0080, 0, 5'b01111, 1, 0));
    reset_n = 1'b0;
    #1 check("mulr_rst", obs, '0);
    for (int k = 0; k < 3; k++) begin
      cyc(); check($sformatf("mulr_low%0d", k), obs, '0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(); check($sformatf("mulr_idle%0d", k), obs, '0);
    end

    // reset during a T1 stall
    start = 1'b1;
    mem_ready = 1'b0;
    cyc(); check("st_t0", obs, ev(E_T0, 0, 0, 0, 1, 0));
    start = 1'b0;
    cyc(); check("st_t1", obs, ev(E_T1W, 0, 0, 0, 1, 0));
    reset_n = 1'b0;
    #1 check("st_rst", obs, '0);
    mem_ready = 1'b1;
    #1 reset_n = 1'b1;
    cyc(); check("st_idle", obs, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
